mux_tree_pipe: RTL and testbench
================================

// Module: mux_tree_pipe
// PURPOSE
//  Parametrised, pipelined N-to-1 data-word multiplexer built as a tree of 4:1 stages.
//  Each stage has a register behind it, and the stages are controlled by a valid/ready handshake.
//  It is the generalisation of the team's combinational 16:1 bit mux, for use on wide datapaths.
//  It sits between N producer lanes and one consumer. Back-pressure stalls the whole tree.
// PARAMETERS
//  DATA_W   8   width of each input word and of the output word (1..64)
//  NUM_IN   16  number of input lanes. Must be a power of 2, range 2..64.
//  LEVELS   derived = ceil(log2(NUM_IN)/2). Number of 4:1 levels, which is also the latency in cycles. Not user-set.
// PORTS
//  clk        in   1                  rising-edge clock
//  rst        in   1                  asynchronous, active-high reset
//  in_data    in   NUM_IN*DATA_W      lane i occupies bits [i*DATA_W +: DATA_W]
//  in_sel     in   clog2(NUM_IN)      lane index to forward
//  in_valid   in   1                  in_data/in_sel are valid this cycle
//  in_ready   out  1                  tree accepts a beat this cycle
//  out_data   out  DATA_W             selected word
//  out_valid  out  1                  out_data is valid
//  out_ready  in   1                  consumer accepts out_data
//  out_err    out  1                  beat carried an out-of-range sel (only reachable when widths pad)
//  beat_cnt   out  16                 count of beats delivered (out_valid & out_ready), wraps
// BEHAVIOUR
//  - Reset (async assert, sync-safe release): all stage valids=0, stage data=0,
//    out_data=0, out_valid=0, out_err=0, beat_cnt=0. in_ready=1 in the first cycle after reset.
//  - Inputs are padded with zero lanes up to 4^LEVELS lanes. in_sel is zero-extended to 2*LEVELS bits.
//  - Level k (k=0 first) selects with sel bits [2k+1:2k]. Level k registers its surviving words.
//    It also registers the remaining sel bits [2*LEVELS-1:2k+2], a valid bit and an err bit.
//  - Global advance: adv = out_ready | ~out_valid. in_ready = adv (combinational, no path from in_valid).
//  - Accept: in_valid & in_ready. A stage loads when adv=1; a bubble (valid=0) is loaded if upstream is invalid.
//  - When adv=0, every stage holds. out_data/out_valid stay stable until out_ready (AXI-style hold rule).
//  - Latency: a beat accepted at cycle t appears with out_valid=1 at cycle t+LEVELS, given no stall.
//  - Throughput: 1 beat/cycle when out_ready is held 1.
//  - in_sel >= NUM_IN: out_data=0 and out_err=1 on that beat. The pipeline continues normally.
//    This case is only possible if NUM_IN is not a power of 2, which is illegal. The check remains as a guard.
//  - beat_cnt increments on out_valid & out_ready. It wraps 0xFFFF -> 0x0000.
//  - Simultaneous out handshake and new accept: both take effect in the same cycle; the tree shifts by one.
//  - Reset asserted mid-stream: all in-flight beats are discarded. No partial beat is emitted after release.
//  - NUM_IN=2 case: LEVELS=1. One 4:1 stage with lanes 2,3 zero-padded. Latency 1.
// STRUCTURE
//  - Shared package mux_pkg holds clog2 and levels_f(NUM_IN) functions, plus a typedef for the stage control record {valid, err, sel_rem}.
//  - One sub-module, mux4_stage: parametrised by word count and width.
//    It contains the combinational 4:1 word mux array, the stage registers, and the enable/async-reset logic.
//  - Top level: a generate loop instantiates LEVELS mux4_stage instances, with the adv, in_ready and beat_cnt logic around them.
// TESTING
//  1 Reset: hold rst=1 with random inputs -> out_valid=0, out_data=0, beat_cnt=0, in_ready=1 after release.
//  2 Streaming, NUM_IN=16, DATA_W=8: lane i = 8'h10+i, sel 0..15 back-to-back, out_ready=1.
//    -> out_data 8'h10..8'h1F in order, first at +2 cycles, one per cycle.
//  3 Stall: send sel=5,9,3, then hold out_ready=0 for 4 cycles.
//    -> out_data held at 8'h15, in_ready=0, no loss. After release, 8'h19 then 8'h13 follow.
//  4 Bubbles: in_valid pattern 1,0,1 with sel=15,x,0 -> out_valid pattern 1,0,1, with data 8'h1F then 8'h10.
//  5 Reset mid-stream: 2 beats in flight, pulse rst -> nothing emitted, beat_cnt=0, next beat sel=7 gives 8'h17.
//  6 Param sweep: NUM_IN=2/4/64 and DATA_W=1/32, random sel vs model -> latency 1/1/3, no mismatches.
//    Also preload beat_cnt to 0xFFFF via 65535 beats; one more beat -> 0x0000.

Source files
------------

// File: rtl/mux_tree_pipe_pkg.sv
// Shared definitions for the pipelined 4:1 mux tree: sizing helpers and the
// per-stage control record that travels alongside the data words.
package mux_pkg;

    // Wide enough for the remaining select bits of the largest tree (64 lanes -> 6 bits)
    localparam int SEL_REM_W = 8;

    // Control record carried by every stage next to its data words
    typedef struct packed {
        logic                 valid;
        logic                 err;
        logic [SEL_REM_W-1:0] sel_rem;
    } stage_ctrl_t;

    // Ceiling log2, with clog2(1) = 0
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Number of 4:1 levels needed for n lanes (also the latency in cycles)
    function automatic int levels_f(input int n);
        return (clog2(n) + 1) / 2;
    endfunction

endpackage

// File: rtl/mux_tree_pipe_if.sv
// Producer-side and consumer-side handshake bundle of the mux tree.
interface mux_tree_pipe_if
    import mux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NUM_IN = 16
) ();

    localparam int SEL_W = clog2(NUM_IN);

    logic [NUM_IN*DATA_W-1:0] in_data;
    logic [SEL_W-1:0]         in_sel;
    logic                     in_valid;
    logic                     in_ready;
    logic [DATA_W-1:0]        out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_err;
    logic [15:0]              beat_cnt;

    // Environment side: drives lanes and consumer ready
    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_err, beat_cnt
    );

    // Mux tree side
    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_err, beat_cnt
    );

endinterface

// File: rtl/mux_tree_pipe_stage.sv
// One level of the tree: N_OUT parallel 4:1 word muxes followed by an
// enable-gated register holding the surviving words and the control record.
module mux4_stage
    import mux_pkg::*;
#(
    parameter int N_OUT  = 1,
    parameter int DATA_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [4*N_OUT*DATA_W-1:0] d_in,
    input  stage_ctrl_t               c_in,
    output logic [N_OUT*DATA_W-1:0]   d_q,
    output stage_ctrl_t               c_q
);

    logic [N_OUT*DATA_W-1:0] mux_s;
    stage_ctrl_t             c_nxt_s;

    // Pick one word out of every group of four using the lowest two remaining sel bits
    always_comb begin
        mux_s = '0;
        for (int j = 0; j < N_OUT; j++) begin
            case (c_in.sel_rem[1:0])
                2'd0:    mux_s[j*DATA_W +: DATA_W] = d_in[(4*j+0)*DATA_W +: DATA_W];
                2'd1:    mux_s[j*DATA_W +: DATA_W] = d_in[(4*j+1)*DATA_W +: DATA_W];
                2'd2:    mux_s[j*DATA_W +: DATA_W] = d_in[(4*j+2)*DATA_W +: DATA_W];
                2'd3:    mux_s[j*DATA_W +: DATA_W] = d_in[(4*j+3)*DATA_W +: DATA_W];
                default: mux_s[j*DATA_W +: DATA_W] = '0;
            endcase
        end
    end

    // Consume the two sel bits used here and forward the rest downstream
    always_comb begin
        c_nxt_s         = '0;
        c_nxt_s.valid   = c_in.valid;
        c_nxt_s.err     = c_in.err;
        c_nxt_s.sel_rem = c_in.sel_rem >> 2;
    end

    // Stage register: loads (including bubbles) on advance, holds otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q <= '0;
            c_q <= '0;
        end else if (en) begin
            d_q <= mux_s;
            c_q <= c_nxt_s;
        end else begin
            d_q <= d_q;
            c_q <= c_q;
        end
    end

endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined N-to-1 word multiplexer built from LEVELS registered 4:1 stages.
// The whole tree advances together whenever the output register is free or
// being drained, so back-pressure stalls every stage at once.
module mux_tree_pipe
    import mux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NUM_IN = 16
) (
    input  logic            clk,
    input  logic            rst,
    mux_tree_pipe_if.slave  bus
);

    localparam int SEL_W  = clog2(NUM_IN);
    localparam int LEVELS = levels_f(NUM_IN);
    localparam int NPAD   = 4 ** LEVELS;

    logic                   adv_s;
    logic [SEL_REM_W-1:0]   sel_ext_s;
    logic                   in_err_s;
    stage_ctrl_t            in_ctrl_s;
    logic [NPAD*DATA_W-1:0] pad_data_s;
    logic [DATA_W-1:0]      out_data_s;
    stage_ctrl_t            out_ctrl_s;
    logic [15:0]            beat_cnt_r;

    // Tree moves when the output slot is empty or being taken this cycle
    always_comb begin
        adv_s = bus.out_ready | ~out_ctrl_s.valid;
    end

    // Zero-extend the select and flag lanes that do not exist
    always_comb begin
        sel_ext_s            = '0;
        sel_ext_s[SEL_W-1:0] = bus.in_sel;
        in_err_s             = (int'(sel_ext_s) >= NUM_IN);
    end

    // Control record entering level 0
    always_comb begin
        in_ctrl_s         = '0;
        in_ctrl_s.valid   = bus.in_valid;
        in_ctrl_s.err     = in_err_s;
        in_ctrl_s.sel_rem = sel_ext_s;
    end

    // Pad to a full 4^LEVELS lanes; an out-of-range beat carries all-zero data
    always_comb begin
        pad_data_s = '0;
        if (!in_err_s) begin
            pad_data_s[NUM_IN*DATA_W-1:0] = bus.in_data;
        end else begin
            pad_data_s = '0;
        end
    end

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int NO = 4 ** (LEVELS - k - 1);

        logic [4*NO*DATA_W-1:0] d_in;
        stage_ctrl_t            c_in;
        logic [NO*DATA_W-1:0]   d_q;
        stage_ctrl_t            c_q;

        if (k == 0) begin : g_first
            assign d_in = pad_data_s;
            assign c_in = in_ctrl_s;
        end else begin : g_next
            assign d_in = g_lvl[k-1].d_q;
            assign c_in = g_lvl[k-1].c_q;
        end

        mux4_stage #(
            .N_OUT  (NO),
            .DATA_W (DATA_W)
        ) u_stage (
            .clk  (clk),
            .rst  (rst),
            .en   (adv_s),
            .d_in (d_in),
            .c_in (c_in),
            .d_q  (d_q),
            .c_q  (c_q)
        );

        if (k == LEVELS - 1) begin : g_last
            assign out_data_s = d_q;
            assign out_ctrl_s = c_q;
        end
    end

    // Delivered-beat counter, free-running with wrap-around
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt_r <= 16'd0;
        end else if (out_ctrl_s.valid && bus.out_ready) begin
            beat_cnt_r <= beat_cnt_r + 16'd1;
        end else begin
            beat_cnt_r <= beat_cnt_r;
        end
    end

    assign bus.in_ready  = adv_s;
    assign bus.out_data  = out_data_s;
    assign bus.out_valid = out_ctrl_s.valid;
    // Leftover sel bits after the last level also mean the lane did not exist
    assign bus.out_err   = out_ctrl_s.err | (|out_ctrl_s.sel_rem);
    assign bus.beat_cnt  = beat_cnt_r;

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Directed bench for mux_tree_pipe: a 16x8 main instance plus 2x1, 4x32 and
// 64x32 instances for the parameter sweep.
module tb_mux_tree_pipe;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    mux_tree_pipe_if #(.DATA_W(8),  .NUM_IN(16)) m ();
    mux_tree_pipe_if #(.DATA_W(1),  .NUM_IN(2))  a ();
    mux_tree_pipe_if #(.DATA_W(32), .NUM_IN(4))  b ();
    mux_tree_pipe_if #(.DATA_W(32), .NUM_IN(64)) c ();

    mux_tree_pipe #(.DATA_W(8),  .NUM_IN(16)) dut_m (.clk(clk), .rst(rst), .bus(m.slave));
    mux_tree_pipe #(.DATA_W(1),  .NUM_IN(2))  dut_a (.clk(clk), .rst(rst), .bus(a.slave));
    mux_tree_pipe #(.DATA_W(32), .NUM_IN(4))  dut_b (.clk(clk), .rst(rst), .bus(b.slave));
    mux_tree_pipe #(.DATA_W(32), .NUM_IN(64)) dut_c (.clk(clk), .rst(rst), .bus(c.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [1:0]  ad;
    logic [31:0] bw [4];
    logic [31:0] cw [64];
    logic        exp2  [20];
    logic [31:0] exp4  [20];
    logic [31:0] exp64 [20];

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        a.in_data = '0; a.in_sel = '0; a.in_valid = 1'b0; a.out_ready = 1'b1;
        b.in_data = '0; b.in_sel = '0; b.in_valid = 1'b0; b.out_ready = 1'b1;
        c.in_data = '0; c.in_sel = '0; c.in_valid = 1'b0; c.out_ready = 1'b1;

        // 1: reset held with random activity on the inputs
        m.in_data   = {$urandom, $urandom, $urandom, $urandom};
        m.in_sel    = 4'($urandom);
        m.in_valid  = 1'b1;
        m.out_ready = 1'b1;
        tick; tick; tick;
        chk("rst_out_valid", 64'(m.out_valid), 64'd0);
        chk("rst_out_data",  64'(m.out_data),  64'd0);
        chk("rst_beat_cnt",  64'(m.beat_cnt),  64'd0);
        chk("rst_out_err",   64'(m.out_err),   64'd0);
        chk("rst_c_valid",   64'(c.out_valid), 64'd0);
        m.in_valid  = 1'b0;
        m.out_ready = 1'b0;
        rst = 1'b0;
        #1;
        chk("rel_in_ready", 64'(m.in_ready), 64'd1);
        tick;
        chk("rel_idle_valid", 64'(m.out_valid), 64'd0);

        // 2: streaming sel 0..15 back-to-back
        for (int i = 0; i < 16; i++) begin
            m.in_data[i*8 +: 8] = 8'h10 + 8'(i);
        end
        m.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            m.in_sel   = 4'(i);
            m.in_valid = 1'b1;
            tick;
            if (i == 0) begin
                chk("stream_lat", 64'(m.out_valid), 64'd0);
            end else begin
                chk($sformatf("stream_v%0d", i - 1), 64'(m.out_valid), 64'd1);
                chk($sformatf("stream_d%0d", i - 1), 64'(m.out_data), 64'(8'h10 + 8'(i - 1)));
            end
        end
        m.in_valid = 1'b0;
        tick;
        chk("stream_d15", 64'(m.out_data), 64'h1f);
        chk("stream_err", 64'(m.out_err),  64'd0);
        tick;
        chk("stream_drained", 64'(m.out_valid), 64'd0);
        chk("stream_cnt",     64'(m.beat_cnt),  64'd16);

        // 3: stall with three beats queued
        m.in_sel = 4'd5; m.in_valid = 1'b1; tick;
        m.in_sel = 4'd9; tick;
        chk("stall_first", 64'(m.out_data), 64'h15);
        m.in_sel = 4'd3; m.out_ready = 1'b0;
        #1;
        chk("stall_in_ready", 64'(m.in_ready), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick;
            chk($sformatf("stall_hold_d%0d", i), 64'(m.out_data),  64'h15);
            chk($sformatf("stall_hold_v%0d", i), 64'(m.out_valid), 64'd1);
            chk($sformatf("stall_rdy%0d", i),    64'(m.in_ready),  64'd0);
        end
        m.out_ready = 1'b1;
        #1;
        chk("stall_rel_ready", 64'(m.in_ready), 64'd1);
        tick;
        m.in_valid = 1'b0;
        chk("stall_next1", 64'(m.out_data), 64'h19);
        tick;
        chk("stall_next2", 64'(m.out_data),  64'h13);
        chk("stall_v2",    64'(m.out_valid), 64'd1);
        tick;
        chk("stall_drained", 64'(m.out_valid), 64'd0);
        chk("stall_cnt",     64'(m.beat_cnt),  64'd19);

        // 4: bubbles in the input stream
        m.in_sel = 4'd15; m.in_valid = 1'b1; tick;
        chk("bub_v0", 64'(m.out_valid), 64'd0);
        m.in_sel = 4'd7;  m.in_valid = 1'b0; tick;
        chk("bub_v1", 64'(m.out_valid), 64'd1);
        chk("bub_d1", 64'(m.out_data),  64'h1f);
        m.in_sel = 4'd0;  m.in_valid = 1'b1; tick;
        chk("bub_v2", 64'(m.out_valid), 64'd0);
        m.in_valid = 1'b0; tick;
        chk("bub_v3", 64'(m.out_valid), 64'd1);
        chk("bub_d3", 64'(m.out_data),  64'h10);
        tick;
        chk("bub_cnt", 64'(m.beat_cnt), 64'd21);

        // 5: reset while two beats are in flight
        m.in_sel = 4'd1; m.in_valid = 1'b1; tick;
        m.in_sel = 4'd2; tick;
        m.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mrst_valid", 64'(m.out_valid), 64'd0);
        chk("mrst_cnt",   64'(m.beat_cnt),  64'd0);
        tick;
        rst = 1'b0;
        tick;
        chk("mrst_quiet1", 64'(m.out_valid), 64'd0);
        tick;
        chk("mrst_quiet2", 64'(m.out_valid), 64'd0);
        chk("mrst_cnt2",   64'(m.beat_cnt),  64'd0);
        m.in_sel = 4'd7; m.in_valid = 1'b1; tick;
        m.in_valid = 1'b0; tick;
        chk("mrst_v7", 64'(m.out_valid), 64'd1);
        chk("mrst_d7", 64'(m.out_data),  64'h17);
        tick;
        chk("mrst_cnt3", 64'(m.beat_cnt), 64'd1);

        // 6: parameter sweep with random lanes and selects
        for (int i = 0; i < 20; i++) begin
            ad = 2'($urandom);
            a.in_data  = ad;
            a.in_sel   = 1'($urandom);
            a.in_valid = 1'b1;
            exp2[i]    = ad[a.in_sel];
            for (int j = 0; j < 4; j++) begin
                bw[j] = $urandom;
                b.in_data[j*32 +: 32] = bw[j];
            end
            b.in_sel   = 2'($urandom);
            b.in_valid = 1'b1;
            exp4[i]    = bw[b.in_sel];
            for (int j = 0; j < 64; j++) begin
                cw[j] = $urandom;
                c.in_data[j*32 +: 32] = cw[j];
            end
            c.in_sel   = 6'($urandom);
            c.in_valid = 1'b1;
            exp64[i]   = cw[c.in_sel];
            tick;
            chk($sformatf("n2_v%0d", i), 64'(a.out_valid), 64'd1);
            chk($sformatf("n2_d%0d", i), 64'(a.out_data),  64'(exp2[i]));
            chk($sformatf("n4_v%0d", i), 64'(b.out_valid), 64'd1);
            chk($sformatf("n4_d%0d", i), 64'(b.out_data),  64'(exp4[i]));
            if (i >= 2) begin
                chk($sformatf("n64_v%0d", i - 2), 64'(c.out_valid), 64'd1);
                chk($sformatf("n64_d%0d", i - 2), 64'(c.out_data),  64'(exp64[i-2]));
            end else begin
                chk($sformatf("n64_lat%0d", i), 64'(c.out_valid), 64'd0);
            end
        end
        a.in_valid = 1'b0;
        b.in_valid = 1'b0;
        c.in_valid = 1'b0;
        tick;
        chk("n2_drained", 64'(a.out_valid), 64'd0);
        chk("n64_d18",    64'(c.out_data),  64'(exp64[18]));
        tick;
        chk("n64_d19",    64'(c.out_data),  64'(exp64[19]));
        chk("n64_err",    64'(c.out_err),   64'd0);
        chk("n64_cnt",    64'(c.beat_cnt),  64'd19);
        tick;
        chk("n64_drained", 64'(c.out_valid), 64'd0);
        chk("n64_cnt2",    64'(c.beat_cnt),  64'd20);

        // beat counter wrap: 65535 beats then one more
        rst = 1'b1;
        tick;
        rst = 1'b0;
        m.out_ready = 1'b1;
        m.in_valid  = 1'b1;
        for (int n = 0; n < 65535; n++) begin
            m.in_sel = 4'(n);
            tick;
        end
        m.in_valid = 1'b0;
        tick;
        tick;
        chk("wrap_ffff",  64'(m.beat_cnt),  64'hffff);
        chk("wrap_idle",  64'(m.out_valid), 64'd0);
        m.in_sel = 4'd3; m.in_valid = 1'b1; tick;
        m.in_valid = 1'b0; tick;
        chk("wrap_last_d", 64'(m.out_data), 64'h13);
        tick;
        chk("wrap_zero", 64'(m.beat_cnt), 64'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
